// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline control bundle between the stall/flush sequencer and the rest of
// the RV32I pipeline.
//   master : pipeline side; drives hazard/memory/halt requests and observes
//            the per-stage enables, flushes, status and perf counters.
//   slave  : the sequencer (pipeline_stall_ctrl).
// Parameter CNT_W sets the performance counter width.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use;
  logic             redirect_ex;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             halt_req;
  logic             resume;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             mem_wb_flush;
  logic [1:0]       state_o;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output load_use, redirect_ex, imem_ready, dmem_req, dmem_ready, halt_req, resume,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush,
    input  state_o, halted, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  load_use, redirect_ex, imem_ready, dmem_req, dmem_ready, halt_req, resume,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush,
    output state_o, halted, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Merges load-use stalls, EX redirects, imem/dmem wait handshakes and halt
// requests into per-stage write enables and flushes. Enables/flushes are
// combinational from the registered state plus the current inputs.
// States: RUN=0, MEM_WAIT=1 (dmem wait with timeout), DRAIN=2 (empty the
// pipe before halting), HALTED=3.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : pipeline_stall_ctrl_if.slave (requests in, controls/status out)
// Parameters: MEM_TIMEOUT (max MEM_WAIT cycles), DRAIN_CYCLES (>=1), CNT_W.
// Build option: define PIPE_PERF_CNT_EN to implement stall_cnt/flush_cnt;
// otherwise both ports read as zero and no counter flops exist.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [WW-1:0] WAIT_ZERO  = {WW{1'b0}};
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0] DRAIN_ZERO = {DW{1'b0}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t        state_r, state_nx_s;
  logic [WW-1:0] wait_cnt_r, wait_nx_s;
  logic [DW-1:0] drain_cnt_r, drain_nx_s;
  logic          ret_drain_r, ret_nx_s;
  logic          mem_timeout_r, timeout_nx_s;

  logic mem_stall_s;
  logic frozen_s;
  logic act_s;
  logic drain_mode_s;
  logic halt_out_s;
  logic pc_we_s, if_id_we_s, if_id_flush_s, id_ex_we_s, id_ex_flush_s, ex_mem_we_s, mem_wb_flush_s;

  assign mem_stall_s = bus.dmem_req && !bus.dmem_ready;

  // Next-state decision and per-stage enable/flush generation.
  always_comb begin
    state_nx_s     = state_r;
    wait_nx_s      = wait_cnt_r;
    drain_nx_s     = drain_cnt_r;
    ret_nx_s       = ret_drain_r;
    timeout_nx_s   = mem_timeout_r;
    frozen_s       = 1'b0;
    act_s          = 1'b0;
    drain_mode_s   = 1'b0;
    halt_out_s     = 1'b0;
    pc_we_s        = 1'b1;
    if_id_we_s     = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_we_s     = 1'b1;
    id_ex_flush_s  = 1'b0;
    ex_mem_we_s    = 1'b1;
    mem_wb_flush_s = 1'b0;

    case (state_r)
      RUN: begin
        if (mem_stall_s) begin
          frozen_s   = 1'b1;
          state_nx_s = MEM_WAIT;
          wait_nx_s  = WAIT_ZERO;
          ret_nx_s   = 1'b0;
        end else begin
          act_s = 1'b1;
        end
      end
      DRAIN: begin
        // Fetch side stays shut for the whole drain, frozen or not.
        drain_mode_s = 1'b1;
        if (mem_stall_s) begin
          frozen_s = 1'b1;
        end else begin
          act_s = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          // Access completes: the rest of the pipe resolves this same cycle.
          act_s        = 1'b1;
          drain_mode_s = ret_drain_r;
          wait_nx_s    = WAIT_ZERO;
          state_nx_s   = ret_drain_r ? DRAIN : RUN;
        end else begin
          frozen_s = 1'b1;
          if (wait_cnt_r == WAIT_LAST) begin
            timeout_nx_s = 1'b1;
            wait_nx_s    = WAIT_ZERO;
            state_nx_s   = HALTED;
          end else begin
            wait_nx_s = wait_cnt_r + WAIT_ONE;
          end
        end
      end
      HALTED: begin
        halt_out_s = 1'b1;
        if (bus.resume) begin
          state_nx_s   = RUN;
          timeout_nx_s = 1'b0;
        end else begin
          state_nx_s = HALTED;
        end
      end
      default: begin
        state_nx_s = RUN;
      end
    endcase

    if (frozen_s) begin
      pc_we_s        = 1'b0;
      if_id_we_s     = 1'b0;
      id_ex_we_s     = 1'b0;
      ex_mem_we_s    = 1'b0;
      mem_wb_flush_s = 1'b1;
    end else if (act_s) begin
      if (bus.redirect_ex) begin
        if_id_flush_s = 1'b1;
        id_ex_flush_s = 1'b1;
      end else if (bus.load_use) begin
        pc_we_s       = 1'b0;
        if_id_we_s    = 1'b0;
        id_ex_flush_s = 1'b1;
      end else if (!bus.imem_ready) begin
        pc_we_s       = 1'b0;
        if_id_flush_s = 1'b1;
      end else if (bus.halt_req && !drain_mode_s) begin
        pc_we_s       = 1'b0;
        if_id_flush_s = 1'b1;
        state_nx_s    = DRAIN;
        drain_nx_s    = DRAIN_LAST;
      end else begin
        pc_we_s = 1'b1;
      end
      // Drain progress only counts cycles where the back end moved.
      if (drain_mode_s) begin
        if (drain_cnt_r == DRAIN_ZERO) begin
          state_nx_s = HALTED;
        end else begin
          state_nx_s = DRAIN;
          drain_nx_s = drain_cnt_r - DRAIN_ONE;
        end
      end else begin
        drain_nx_s = drain_nx_s;
      end
    end else if (halt_out_s) begin
      pc_we_s     = 1'b0;
      if_id_we_s  = 1'b0;
      id_ex_we_s  = 1'b0;
      ex_mem_we_s = 1'b0;
    end else begin
      pc_we_s = pc_we_s;
    end

    if (drain_mode_s) begin
      pc_we_s       = 1'b0;
      if_id_flush_s = 1'b1;
    end else begin
      if_id_flush_s = if_id_flush_s;
    end

    // Reset holds every stage and bubbles the pipe, independent of state.
    if (rst) begin
      pc_we_s        = 1'b0;
      if_id_we_s     = 1'b0;
      id_ex_we_s     = 1'b0;
      ex_mem_we_s    = 1'b0;
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      mem_wb_flush_s = 1'b1;
    end else begin
      mem_wb_flush_s = mem_wb_flush_s;
    end
  end

  // State, wait/drain counters, return flag and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= WAIT_ZERO;
      drain_cnt_r   <= DRAIN_ZERO;
      ret_drain_r   <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      wait_cnt_r    <= wait_nx_s;
      drain_cnt_r   <= drain_nx_s;
      ret_drain_r   <= ret_nx_s;
      mem_timeout_r <= timeout_nx_s;
    end
  end

  assign bus.pc_we        = pc_we_s;
  assign bus.if_id_we     = if_id_we_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_we     = id_ex_we_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.ex_mem_we    = ex_mem_we_s;
  assign bus.mem_wb_flush = mem_wb_flush_s;
  assign bus.state_o      = state_r;
  assign bus.halted       = (state_r == HALTED);
  assign bus.mem_timeout  = mem_timeout_r;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             stall_inc_s, flush_inc_s;

  // Redirect is the top-priority action, so act_s plus redirect means it applied.
  assign stall_inc_s = !pc_we_s && (state_r != HALTED);
  assign flush_inc_s = act_s && bus.redirect_ex;

  // Free-running perf counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, stall_inc_s};
      flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, flush_inc_s};
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: the stimulus process pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_stall_ctrl;

  // Input vector order: {load_use, redirect_ex, imem_ready, dmem_req, dmem_ready, halt_req, resume}
  localparam logic [6:0] I_IDLE = 7'b0010000;
  localparam logic [6:0] I_NOIM = 7'b0000000;
  localparam logic [6:0] I_LU   = 7'b1010000;
  localparam logic [6:0] I_RX   = 7'b0110000;
  localparam logic [6:0] I_ALL3 = 7'b1110010;
  localparam logic [6:0] I_DW   = 7'b0011000;
  localparam logic [6:0] I_DR   = 7'b0011100;
  localparam logic [6:0] I_DRLU = 7'b1011100;
  localparam logic [6:0] I_HR   = 7'b0010010;
  localparam logic [6:0] I_RS   = 7'b0010001;

  // Output vector order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush}
  localparam logic [6:0] O_NORM = 7'b1101010;
  localparam logic [6:0] O_LU   = 7'b0001110;
  localparam logic [6:0] O_RD   = 7'b1111110;
  localparam logic [6:0] O_NOF  = 7'b0111010;  // fetch stalled / drain
  localparam logic [6:0] O_DRD  = 7'b0111110;  // drain + redirect
  localparam logic [6:0] O_FRZ  = 7'b0000001;
  localparam logic [6:0] O_DFRZ = 7'b0010001;  // frozen while draining
  localparam logic [6:0] O_HALT = 7'b0000000;
  localparam logic [6:0] O_RST  = 7'b0010101;

  typedef struct {
    logic       rs;
    logic [6:0] o;
    logic [1:0] st;
    logic       hl;
    logic       to;
    logic       rd;
    string      nm;
  } exp_t;

  logic clk;
  logic rst;
  int   ntests;
  int   nfail;
  int   exp_stall;
  int   exp_flush;
  exp_t sb[$];
  exp_t cur_e;

  pipeline_stall_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (8),
    .DRAIN_CYCLES(4),
    .CNT_W       (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One stimulus cycle: drive just after the rising edge, queue the expectation.
  task automatic cyc(input logic r, input logic [6:0] in, input logic [6:0] o,
                     input logic [1:0] st, input logic hl, input logic to,
                     input logic rd, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    {bus.load_use, bus.redirect_ex, bus.imem_ready, bus.dmem_req,
     bus.dmem_ready, bus.halt_req, bus.resume} = in;
    e.rs = r; e.o = o; e.st = st; e.hl = hl; e.to = to; e.rd = rd; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur_e = sb.pop_front();
      chk({cur_e.nm, ".outs"},
          {57'd0, bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_we,
           bus.id_ex_flush, bus.ex_mem_we, bus.mem_wb_flush},
          {57'd0, cur_e.o});
      chk({cur_e.nm, ".state"}, {62'd0, bus.state_o}, {62'd0, cur_e.st});
      chk({cur_e.nm, ".halted"}, {63'd0, bus.halted}, {63'd0, cur_e.hl});
      chk({cur_e.nm, ".timeout"}, {63'd0, bus.mem_timeout}, {63'd0, cur_e.to});
`ifdef PIPE_PERF_CNT_EN
      chk({cur_e.nm, ".stall_cnt"}, {32'd0, bus.stall_cnt}, cur_e.rs ? 64'd0 : 64'(exp_stall));
      chk({cur_e.nm, ".flush_cnt"}, {32'd0, bus.flush_cnt}, cur_e.rs ? 64'd0 : 64'(exp_flush));
`else
      chk({cur_e.nm, ".stall_cnt"}, {32'd0, bus.stall_cnt}, 64'd0);
      chk({cur_e.nm, ".flush_cnt"}, {32'd0, bus.flush_cnt}, 64'd0);
`endif
      if (cur_e.rs) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (!cur_e.o[6] && (cur_e.st != 2'd3)) exp_stall++;
        if (cur_e.rd) exp_flush++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ntests = 0;
    nfail = 0;
    exp_stall = 0;
    exp_flush = 0;
    rst = 1'b1;
    {bus.load_use, bus.redirect_ex, bus.imem_ready, bus.dmem_req,
     bus.dmem_ready, bus.halt_req, bus.resume} = I_IDLE;

    // reset state
    cyc(1'b1, I_IDLE, O_RST,  2'd0, 1'b0, 1'b0, 1'b0, "rst0");
    cyc(1'b1, I_IDLE, O_RST,  2'd0, 1'b0, 1'b0, 1'b0, "rst1");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "run");
    // load-use bubble
    cyc(1'b0, I_LU,   O_LU,   2'd0, 1'b0, 1'b0, 1'b0, "lu");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "lu_after");
    // redirect beats load-use and halt
    cyc(1'b0, I_ALL3, O_RD,   2'd0, 1'b0, 1'b0, 1'b1, "prio");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "prio_after");
    // 3-cycle dmem wait
    cyc(1'b0, I_DW,   O_FRZ,  2'd0, 1'b0, 1'b0, 1'b0, "dw0");
    cyc(1'b0, I_DW,   O_FRZ,  2'd1, 1'b0, 1'b0, 1'b0, "dw1");
    cyc(1'b0, I_DW,   O_FRZ,  2'd1, 1'b0, 1'b0, 1'b0, "dw2");
    cyc(1'b0, I_DR,   O_NORM, 2'd1, 1'b0, 1'b0, 1'b0, "dw_ready");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "dw_back");
    // ready with load-use applies rule 3 in the completing cycle
    cyc(1'b0, I_DW,   O_FRZ,  2'd0, 1'b0, 1'b0, 1'b0, "dwl0");
    cyc(1'b0, I_DRLU, O_LU,   2'd1, 1'b0, 1'b0, 1'b0, "dwl_ready");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "dwl_back");
    // instruction fetch not ready
    cyc(1'b0, I_NOIM, O_NOF,  2'd0, 1'b0, 1'b0, 1'b0, "noim");
    // timeout after 8 MEM_WAIT cycles
    cyc(1'b0, I_DW,   O_FRZ,  2'd0, 1'b0, 1'b0, 1'b0, "to_enter");
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, I_DW, O_FRZ,  2'd1, 1'b0, 1'b0, 1'b0, $sformatf("to_wait%0d", i));
    end
    cyc(1'b0, I_IDLE, O_HALT, 2'd3, 1'b1, 1'b1, 1'b0, "to_halted");
    cyc(1'b0, I_HR,   O_HALT, 2'd3, 1'b1, 1'b1, 1'b0, "to_hr_ignored");
    cyc(1'b0, I_RS,   O_HALT, 2'd3, 1'b1, 1'b1, 1'b0, "to_resume");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "to_run");
    cyc(1'b0, I_RS,   O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "resume_ignored");
    // halt: 4 drain cycles then HALTED
    cyc(1'b0, I_HR,   O_NOF,  2'd0, 1'b0, 1'b0, 1'b0, "halt_req");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, I_IDLE, O_NOF, 2'd2, 1'b0, 1'b0, 1'b0, $sformatf("drain%0d", i));
    end
    cyc(1'b0, I_IDLE, O_HALT, 2'd3, 1'b1, 1'b0, 1'b0, "halted");
    cyc(1'b0, I_RS,   O_HALT, 2'd3, 1'b1, 1'b0, 1'b0, "halt_resume");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "halt_run");
    // drain with redirect and memory freeze, then reset mid-drain
    cyc(1'b0, I_HR,   O_NOF,  2'd0, 1'b0, 1'b0, 1'b0, "d2_req");
    cyc(1'b0, I_RX,   O_DRD,  2'd2, 1'b0, 1'b0, 1'b1, "d2_redirect");
    cyc(1'b0, I_DW,   O_DFRZ, 2'd2, 1'b0, 1'b0, 1'b0, "d2_frozen");
    cyc(1'b1, I_IDLE, O_RST,  2'd0, 1'b0, 1'b0, 1'b0, "d2_rst");
    cyc(1'b1, I_IDLE, O_RST,  2'd0, 1'b0, 1'b0, 1'b0, "d2_rst_hold");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "d2_run");
    cyc(1'b0, I_IDLE, O_NORM, 2'd0, 1'b0, 1'b0, 1'b0, "d2_run2");

    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(negedge clk);
    end
    #1;
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL drain_queue: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
